// File: rtl/fa_result_checker.sv
// fa_result_checker: downstream scoreboard for a WIDTH-bit ripple full adder.
// Recomputes a + b + c_in for each vector presented with in_valid while a run
// is active. It counts checked vectors and mismatches, and raises done/pass
// once the programmed number of vectors has been consumed.
//
// Optional feature macro: FIRST_ERR_CAPTURE_EN. When defined, the operands of
// the first mismatching vector in a run are captured on the first_err_* ports.
//
// Handshake: one vector is accepted on each rising edge where in_valid=1 and
// the checker is in RUN. There is no backpressure, so a vector offered in
// IDLE or DONE is dropped. start is a one-cycle request that is honoured in
// IDLE and DONE and ignored in RUN.
module fa_result_checker #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vectors,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic [WIDTH-1:0] sum,
  input  logic             c_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] vec_count,
  output logic             err_flag,
`ifdef FIRST_ERR_CAPTURE_EN
  output logic [WIDTH-1:0] first_err_a,
  output logic [WIDTH-1:0] first_err_b,
  output logic             first_err_cin,
  output logic             first_err_vld,
`endif
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_target;
  logic [CNT_W-1:0] r_vec_count;
  logic [CNT_W-1:0] r_err_count;
  logic             r_err_flag;

  logic [WIDTH:0]   w_expected;
  logic             w_mismatch;
  logic             w_start_run;
  logic             w_accept;
  logic [CNT_W-1:0] w_vec_next;
  logic [CNT_W-1:0] w_err_next;
  logic             w_last;

  // The reference sum is WIDTH+1 bits wide so that the carry-out is the top bit.
  assign w_expected  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c_in};
  assign w_mismatch  = ({c_out, sum} != w_expected);
  assign w_start_run = start && (r_state != S_RUN);
  assign w_accept    = in_valid && (r_state == S_RUN);
  // Both counters saturate at all-ones instead of wrapping.
  assign w_vec_next  = (r_vec_count == '1) ? r_vec_count : r_vec_count + CNT_W'(1);
  assign w_err_next  = (r_err_count == '1) ? r_err_count : r_err_count + CNT_W'(1);
  assign w_last      = w_accept && (w_vec_next == r_target);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state logic. A start in DONE behaves the same as a start in IDLE.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) w_next_state = (num_vectors == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if (w_last) w_next_state = S_DONE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Run target, counters and the per-vector mismatch flag. A vector that
  // arrives in the same IDLE cycle as start is not counted, because the
  // checker is not yet in RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_target    <= '0;
      r_vec_count <= '0;
      r_err_count <= '0;
      r_err_flag  <= 1'b0;
    end else if (w_start_run) begin
      r_target    <= num_vectors;
      r_vec_count <= '0;
      r_err_count <= '0;
      r_err_flag  <= 1'b0;
    end else if (w_accept) begin
      r_vec_count <= w_vec_next;
      if (w_mismatch) r_err_count <= w_err_next;
      r_err_flag  <= w_mismatch;
    end else begin
      r_err_flag  <= 1'b0;
    end
  end

`ifdef FIRST_ERR_CAPTURE_EN
  logic [WIDTH-1:0] r_first_err_a;
  logic [WIDTH-1:0] r_first_err_b;
  logic             r_first_err_cin;
  logic             r_first_err_vld;

  // Capture the operands of the first mismatch in a run. Later mismatches
  // leave the captured values alone.
  always_ff @(posedge clk) begin
    if (rst || w_start_run) begin
      r_first_err_a   <= '0;
      r_first_err_b   <= '0;
      r_first_err_cin <= 1'b0;
      r_first_err_vld <= 1'b0;
    end else if (w_accept && w_mismatch && !r_first_err_vld) begin
      r_first_err_a   <= a;
      r_first_err_b   <= b;
      r_first_err_cin <= c_in;
      r_first_err_vld <= 1'b1;
    end
  end

  assign first_err_a   = r_first_err_a;
  assign first_err_b   = r_first_err_b;
  assign first_err_cin = r_first_err_cin;
  assign first_err_vld = r_first_err_vld;
`endif

  assign busy      = (r_state == S_RUN);
  assign done      = (r_state == S_DONE);
  assign pass      = (r_state == S_DONE) && (r_err_count == '0);
  assign err_count = r_err_count;
  assign vec_count = r_vec_count;
  assign err_flag  = r_err_flag;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_fa_result_checker.sv
// tb_fa_result_checker: directed bench for fa_result_checker.
// Build with FIRST_ERR_CAPTURE_EN defined to also check the first-error
// capture ports.
module tb_fa_result_checker;

  localparam int WIDTH = 4;
  localparam int CNT_W = 16;

  // Clock and reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             start = 1'b0;
  logic [CNT_W-1:0] num_vectors = '0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             c_in = 1'b0;
  logic [WIDTH-1:0] sum = '0;
  logic             c_out = 1'b0;
  logic             busy, done, pass, err_flag;
  logic [CNT_W-1:0] err_count, vec_count;
  logic [1:0]       dbg_state;
`ifdef FIRST_ERR_CAPTURE_EN
  logic [WIDTH-1:0] first_err_a, first_err_b;
  logic             first_err_cin, first_err_vld;
`endif

  fa_result_checker #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .num_vectors(num_vectors),
    .in_valid(in_valid), .a(a), .b(b), .c_in(c_in), .sum(sum), .c_out(c_out),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .vec_count(vec_count), .err_flag(err_flag),
`ifdef FIRST_ERR_CAPTURE_EN
    .first_err_a(first_err_a), .first_err_b(first_err_b),
    .first_err_cin(first_err_cin), .first_err_vld(first_err_vld),
`endif
    .dbg_state(dbg_state)
  );

  // Scoreboard: expected err_flag per accepted vector, plus a count model.
  logic [0:0] exp_q[$];
  int         model_vec;
  int         model_err;
  int         n_tests = 0;
  int         n_fail  = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Driver: pulse start for one cycle and reset the count model.
  task automatic do_start(input int n);
    start = 1'b1;
    num_vectors = CNT_W'(n);
    model_vec = 0;
    model_err = 0;
    exp_q.delete();
    tick();
    start = 1'b0;
  endtask

  // Driver: present one vector for one cycle, then check err_flag and vec_count.
  task automatic send(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                      input logic tc, input logic [WIDTH-1:0] ts, input logic tco);
    logic [WIDTH:0] e;
    logic           m;
    e = {1'b0, ta} + {1'b0, tb_v} + (WIDTH+1)'(tc);
    m = ({tco, ts} != e);
    in_valid = 1'b1;
    a = ta; b = tb_v; c_in = tc; sum = ts; c_out = tco;
    exp_q.push_back(m);
    model_vec++;
    if (m) model_err++;
    tick();
    in_valid = 1'b0;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL sb_empty: observed 0 entries expected 1");
    end else begin
      chk("err_flag", 32'(err_flag), 32'(exp_q.pop_front()));
    end
    chk("vec_count_step", 32'(vec_count), 32'(model_vec));
  endtask

  task automatic send_good(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v, input logic tc);
    logic [WIDTH:0] s;
    s = {1'b0, ta} + {1'b0, tb_v} + (WIDTH+1)'(tc);
    send(ta, tb_v, tc, s[WIDTH-1:0], s[WIDTH]);
  endtask

  initial begin
    logic [WIDTH:0]   s;
    logic [WIDTH-1:0] ra, rb, rs;
    logic             rc;

    // Reset state
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_pass", 32'(pass), 0);
    chk("rst_err_count", 32'(err_count), 0);
    chk("rst_vec_count", 32'(vec_count), 0);
    chk("rst_err_flag", 32'(err_flag), 0);
    chk("rst_state", 32'(dbg_state), 0);

    // Reset mid-run after 3 vectors; the third vector carries an error
    do_start(10);
    chk("mr_busy", 32'(busy), 1);
    send_good(4'd1, 4'd2, 1'b0);
    send_good(4'd3, 4'd4, 1'b1);
    send(4'd5, 4'd5, 1'b0, 4'd9, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_busy_after", 32'(busy), 0);
    chk("mr_done_after", 32'(done), 0);
    chk("mr_vec_count", 32'(vec_count), 0);
    chk("mr_err_count", 32'(err_count), 0);
    chk("mr_err_flag", 32'(err_flag), 0);

    // Clean run of 4 vectors
    do_start(4);
    send(4'd0, 4'd0, 1'b0, 4'd0, 1'b0);
    send(4'd1, 4'd0, 1'b0, 4'd1, 1'b0);
    send(4'd2, 4'd1, 1'b0, 4'd3, 1'b0);
    send(4'd0, 4'd5, 1'b0, 4'd5, 1'b0);
    chk("clean_done", 32'(done), 1);
    chk("clean_busy", 32'(busy), 0);
    chk("clean_pass", 32'(pass), 1);
    chk("clean_err_count", 32'(err_count), 0);
`ifdef FIRST_ERR_CAPTURE_EN
    chk("clean_fe_vld", 32'(first_err_vld), 0);
`endif

    // Injected error in the 2nd of 3 vectors
    do_start(3);
    send(4'd15, 4'd1, 1'b0, 4'd0, 1'b1);
    send(4'd7, 4'd8, 1'b1, 4'd15, 1'b0);
    send(4'd3, 4'd3, 1'b1, 4'd7, 1'b0);
    chk("inj_done", 32'(done), 1);
    chk("inj_err_count", 32'(err_count), 1);
    chk("inj_pass", 32'(pass), 0);
`ifdef FIRST_ERR_CAPTURE_EN
    chk("inj_fe_a", 32'(first_err_a), 7);
    chk("inj_fe_b", 32'(first_err_b), 8);
    chk("inj_fe_cin", 32'(first_err_cin), 1);
    chk("inj_fe_vld", 32'(first_err_vld), 1);
`endif
    tick();
    chk("inj_done_hold", 32'(done), 1);
    chk("inj_err_hold", 32'(err_count), 1);

    // Gaps and a start pulse during RUN: in_valid 1,0,0,1
    do_start(2);
    send_good(4'd6, 4'd6, 1'b0);
    tick();
    chk("gap_err_flag", 32'(err_flag), 0);
    chk("gap_vec_count", 32'(vec_count), 1);
    start = 1'b1;
    num_vectors = 16'd9;
    tick();
    start = 1'b0;
    chk("gap_no_restart_busy", 32'(busy), 1);
    chk("gap_no_restart_vec", 32'(vec_count), 1);
    send_good(4'd9, 4'd9, 1'b1);
    chk("gap_done", 32'(done), 1);
    chk("gap_pass", 32'(pass), 1);

    // Zero-length run, then an in_valid pulse in DONE
    do_start(0);
    chk("zero_done", 32'(done), 1);
    chk("zero_pass", 32'(pass), 1);
    chk("zero_vec_count", 32'(vec_count), 0);
    in_valid = 1'b1;
    a = 4'd1; b = 4'd1; c_in = 1'b0; sum = 4'd0; c_out = 1'b0;
    tick();
    in_valid = 1'b0;
    chk("zero_ignore_vec", 32'(vec_count), 0);
    chk("zero_ignore_err", 32'(err_count), 0);
    chk("zero_ignore_flag", 32'(err_flag), 0);

    // start together with a (bad) vector: that vector is not counted
    in_valid = 1'b1;
    a = 4'd2; b = 4'd2; c_in = 1'b0; sum = 4'd0; c_out = 1'b1;
    do_start(1);
    in_valid = 1'b0;
    chk("sv_busy", 32'(busy), 1);
    chk("sv_vec_count", 32'(vec_count), 0);
    chk("sv_err_count", 32'(err_count), 0);
    send_good(4'd2, 4'd2, 1'b0);
    chk("sv_done", 32'(done), 1);
    chk("sv_pass", 32'(pass), 1);

    // Random run with about one corrupted result in four
    do_start(20);
    for (int i = 0; i < 20; i++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      rc = 1'($urandom_range(0, 1));
      s  = {1'b0, ra} + {1'b0, rb} + 5'(rc);
      rs = s[3:0];
      if ($urandom_range(0, 3) == 0) rs = rs ^ 4'($urandom_range(1, 15));
      send(ra, rb, rc, rs, s[4]);
    end
    chk("rnd_done", 32'(done), 1);
    chk("rnd_err_count", 32'(err_count), 32'(model_err));
    chk("rnd_pass", 32'(pass), (model_err == 0) ? 1 : 0);

    // Exhaustive sweep over all operand combinations
    do_start(512);
    for (int i = 0; i < 512; i++) begin
      send_good(4'(i >> 5), 4'(i >> 1), 1'(i));
    end
    chk("sweep_done", 32'(done), 1);
    chk("sweep_vec_count", 32'(vec_count), 512);
    chk("sweep_err_count", 32'(err_count), 0);
    chk("sweep_pass", 32'(pass), 1);

    // Final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fa_result_checker.md
Name: fa_result_checker

Overview:
- Downstream checking stage for the 4-bit ripple full adder (a, b, c_in -> sum, c_out).
- Samples each operand/result set presented with in_valid and recomputes a + b + c_in internally.
- Counts checked vectors and mismatches, and reports done/pass once a programmed number of vectors has been consumed.
- Sits between the adder and the bench's clocked verification loop, replacing per-cycle ad-hoc comparison with a self-contained scoreboard.

Parameters:
- WIDTH, 4, operand and sum width in bits.
- CNT_W, 16, width of the vector and error counters, and of num_vectors.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; latches num_vectors and begins a run.
- num_vectors  input  CNT_W  number of valid vectors to check in this run.
- in_valid  input  1  operand/result set on a, b, c_in, sum, c_out is valid this cycle.
- a  input  WIDTH  adder operand A.
- b  input  WIDTH  adder operand B.
- c_in  input  1  adder carry-in.
- sum  input  WIDTH  adder sum under test.
- c_out  input  1  adder carry-out under test.
- busy  output  1  high while in RUN.
- done  output  1  high in DONE; held until start or rst.
- pass  output  1  valid when done=1; 1 iff err_count==0.
- err_count  output  CNT_W  mismatches seen this run, saturating.
- vec_count  output  CNT_W  vectors checked this run.
- err_flag  output  1  registered mismatch flag for the vector sampled in the previous cycle.

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous, active-high, sampled on the rising edge of clk.
- Reset values: busy=0, done=0, pass=0, err_count=0, vec_count=0, err_flag=0, target=0, state=IDLE.
- Reference model: expected = {1'b0,a} + {1'b0,b} + c_in, computed at WIDTH+1 bits. mismatch = ({c_out,sum} != expected).
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 -> latch target=num_vectors; clear err_count, vec_count, err_flag.
  - If num_vectors==0, go to DONE; otherwise go to RUN.
- RUN (busy=1):
  - Each cycle with in_valid=1: vec_count+1, err_count+1 if mismatch (saturates at all-ones; vec_count also saturates), err_flag<=mismatch.
  - in_valid=0 -> counters hold, err_flag<=0.
  - When the accepted vector makes vec_count==target, go to DONE on the same edge.
- DONE (done=1): pass=(err_count==0); counters hold. start=1 -> behaves as start from IDLE (new run).
- Latency:
  - err_flag, err_count and vec_count reflect a vector one cycle after the edge on which it was sampled.
  - done rises on the cycle after the last vector is sampled.
- start in RUN: ignored, no restart.
- in_valid in IDLE or DONE: ignored, no counting.
- start and in_valid in the same IDLE cycle: the vector is not counted; counting begins the next cycle.
- rst mid-run: all state returns to reset values on that edge; the partial run is discarded.
- Inputs are sampled only on the clock edge; glitches between edges are irrelevant.

Optional Feature:
- Macro: FIRST_ERR_CAPTURE_EN.
- Defined:
  - Adds outputs first_err_a[WIDTH], first_err_b[WIDTH], first_err_cin[1] and first_err_vld[1].
  - On the first mismatch of a run, these latch a, b and c_in, and first_err_vld<=1.
  - They are not overwritten by later mismatches. All are cleared by rst or start.
- Not defined: these ports and their registers do not exist. All other behaviour is identical.

Test Plan:
- Reset mid-run: rst during RUN after 3 vectors -> next cycle busy=0, done=0, vec_count=0, err_count=0, err_flag=0.
- Clean run: start with num_vectors=4; vectors (a,b,c_in,sum,c_out) = (0,0,0,0,0), (1,0,0,1,0), (2,1,0,3,0), (0,5,0,5,0) on consecutive cycles -> vec_count=4, err_count=0, done=1 one cycle after the 4th vector, pass=1.
- Injected error: start with num_vectors=3; vectors (15,1,0,sum=0,c_out=1) correct, (7,8,1,sum=15,c_out=0) wrong (expected 0/1), (3,3,1,7,0) correct -> err_flag=1 only in the cycle after the 2nd vector; err_count=1; pass=0. With FIRST_ERR_CAPTURE_EN: first_err_a=7, first_err_b=8, first_err_cin=1.
- Gaps and ignores: num_vectors=2; in_valid toggled 1,0,0,1; start pulsed during RUN -> vec_count=2, done asserts after the 4th cycle, no restart.
- Zero length: start with num_vectors=0 -> DONE next cycle, pass=1, vec_count=0. An in_valid pulse in DONE -> no count change.
- Exhaustive sweep: num_vectors=512; all {a,b,c_in} combinations with correct results -> vec_count=512, err_count=0, pass=1.
